// File: rtl/multi_alarm_key_controller.sv
// Keypad-entry controller for the multi-alarm clock: filters PS/2 set-2 bytes, runs the
// IDLE/ENTRY/SHOW_ALARM FSM and issues display-shift, time-load and alarm-load pulses.
module multi_alarm_key_controller #(
  parameter int  NUM_ALARMS = 2,
  parameter int  NUM_DIGITS = 4,
  parameter int  TIMEOUT_S  = 10,
  localparam int SEL_W      = (NUM_ALARMS > 2) ? 2 : 1
) (
  input  logic                  clk256,
  input  logic                  reset,
  input  logic                  one_second,
  input  logic [7:0]            key,
  input  logic                  key_strobe,
  output logic                  alc_shift,
  output logic [3:0]            digit_out,
  output logic                  load_new_time,
  output logic [NUM_ALARMS-1:0] load_alarm,
  output logic                  show_alarm,
  output logic [SEL_W-1:0]      alarm_sel,
  output logic                  entry_active,
  output logic                  entry_clear,
  output logic                  entry_error
);

  localparam logic [7:0] CODE_STAR  = 8'h7C;
  localparam logic [7:0] CODE_MINUS = 8'h7B;
  localparam logic [7:0] CODE_PLUS  = 8'h79;
  localparam logic [7:0] CODE_DOT   = 8'h71;
  localparam logic [7:0] CODE_BRK   = 8'hF0;
  localparam logic [7:0] CODE_EXT   = 8'hE0;

  localparam int         CNT_W     = 4;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(NUM_DIGITS);
  localparam logic [7:0]       TIMEOUT_V = 8'(TIMEOUT_S);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ENTRY = 2'd1,
    S_SHOW  = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    K_NONE, K_DIGIT, K_STAR, K_MINUS, K_PLUS, K_DOT
  } key_kind_e;

  state_e           state;
  logic [CNT_W-1:0] count;
  logic [7:0]       timer;
  logic             brk;
  logic [7:0]       held_key;

  key_kind_e        kind;
  logic [3:0]       dval;
  logic             accept;
  logic             release_byte;
  logic [SEL_W-1:0] sel_inc;

  always_comb begin
    kind = K_NONE;
    dval = 4'd0;
    case (key)
      8'h70: begin kind = K_DIGIT; dval = 4'd0; end
      8'h69: begin kind = K_DIGIT; dval = 4'd1; end
      8'h72: begin kind = K_DIGIT; dval = 4'd2; end
      8'h7A: begin kind = K_DIGIT; dval = 4'd3; end
      8'h6B: begin kind = K_DIGIT; dval = 4'd4; end
      8'h73: begin kind = K_DIGIT; dval = 4'd5; end
      8'h74: begin kind = K_DIGIT; dval = 4'd6; end
      8'h6C: begin kind = K_DIGIT; dval = 4'd7; end
      8'h75: begin kind = K_DIGIT; dval = 4'd8; end
      8'h7D: begin kind = K_DIGIT; dval = 4'd9; end
      CODE_STAR:  kind = K_STAR;
      CODE_MINUS: kind = K_MINUS;
      CODE_PLUS:  kind = K_PLUS;
      CODE_DOT:   kind = K_DOT;
      default:    kind = K_NONE;
    endcase
  end

  // A make is accepted only if it is a listed code, not a release byte and not a typematic repeat.
  assign accept       = key_strobe && !brk && (kind != K_NONE) && (key != held_key);
  assign release_byte = key_strobe && brk && (key != CODE_BRK) && (key != CODE_EXT);
  assign sel_inc      = (alarm_sel == SEL_W'(NUM_ALARMS - 1)) ? '0 : alarm_sel + 1'b1;

  // NOTE: every register here uses non-blocking assignment so all next-state terms read
  // the values from the start of the cycle, regardless of statement order.
  always_ff @(posedge clk256) begin
    if (reset) begin
      state         <= S_IDLE;
      count         <= '0;
      timer         <= '0;
      brk           <= 1'b0;
      held_key      <= '0;
      alc_shift     <= 1'b0;
      digit_out     <= '0;
      load_new_time <= 1'b0;
      load_alarm    <= '0;
      show_alarm    <= 1'b0;
      alarm_sel     <= '0;
      entry_active  <= 1'b0;
      entry_clear   <= 1'b0;
      entry_error   <= 1'b0;
    end else begin
      alc_shift     <= 1'b0;
      load_new_time <= 1'b0;
      load_alarm    <= '0;
      entry_clear   <= 1'b0;
      entry_error   <= 1'b0;

      if (key_strobe) begin
        if (key == CODE_BRK) begin
          brk <= 1'b1;
        end else if (key != CODE_EXT) begin
          if (brk) begin
            brk <= 1'b0;
            if (key == held_key) held_key <= '0;
          end else if (accept) begin
            held_key <= key;
          end
        end
      end

      case (state)
        S_IDLE: begin
          if (accept) begin
            case (kind)
              K_DIGIT: begin
                alc_shift    <= 1'b1;
                digit_out    <= dval;
                count        <= CNT_W'(1);
                timer        <= TIMEOUT_V;
                state        <= S_ENTRY;
                entry_active <= 1'b1;
              end
              K_STAR: begin
                state      <= S_SHOW;
                show_alarm <= 1'b1;
              end
              K_PLUS:  alarm_sel <= sel_inc;
              default: ;
            endcase
          end
        end

        S_ENTRY: begin
          if (accept) begin
            timer <= TIMEOUT_V;
            case (kind)
              K_DIGIT: begin
                if (count < FULL_CNT) begin
                  alc_shift <= 1'b1;
                  digit_out <= dval;
                  count     <= count + 1'b1;
                end
              end
              K_STAR, K_MINUS: begin
                if (count == FULL_CNT) begin
                  if (kind == K_STAR) load_alarm <= NUM_ALARMS'(1) << alarm_sel;
                  else                load_new_time <= 1'b1;
                end else begin
                  entry_error <= 1'b1;
                  entry_clear <= 1'b1;
                end
                state        <= S_IDLE;
                entry_active <= 1'b0;
              end
              K_PLUS: alarm_sel <= sel_inc;
              K_DOT: begin
                entry_clear  <= 1'b1;
                state        <= S_IDLE;
                entry_active <= 1'b0;
              end
              default: ;
            endcase
          end else if (one_second && (timer != 8'd0)) begin
            timer <= timer - 8'd1;
            if (timer == 8'd1) begin
              entry_clear  <= 1'b1;
              state        <= S_IDLE;
              entry_active <= 1'b0;
            end
          end
        end

        S_SHOW: begin
          if (release_byte && (key == CODE_STAR)) begin
            state      <= S_IDLE;
            show_alarm <= 1'b0;
          end
        end

        default: begin
          state        <= S_IDLE;
          show_alarm   <= 1'b0;
          entry_active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_alarm_key_controller.sv
// Directed bench for multi_alarm_key_controller: a byte/expectation table plus hand-written
// timeout and reset sequences. Outputs are compared packed on the falling edge.
module tb_multi_alarm_key_controller;

  logic       clk256 = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic [7:0] key = 8'h00;
  logic       key_strobe = 1'b0;

  logic       alc_shift;
  logic [3:0] digit_out;
  logic       load_new_time;
  logic [1:0] load_alarm;
  logic       show_alarm;
  logic [0:0] alarm_sel;
  logic       entry_active;
  logic       entry_clear;
  logic       entry_error;

  multi_alarm_key_controller #(.NUM_ALARMS(2), .NUM_DIGITS(4), .TIMEOUT_S(10)) dut (
    .clk256(clk256), .reset(reset), .one_second(one_second), .key(key),
    .key_strobe(key_strobe), .alc_shift(alc_shift), .digit_out(digit_out),
    .load_new_time(load_new_time), .load_alarm(load_alarm), .show_alarm(show_alarm),
    .alarm_sel(alarm_sel), .entry_active(entry_active), .entry_clear(entry_clear),
    .entry_error(entry_error)
  );

  always #5 clk256 = ~clk256;

  int passed = 0;
  int total  = 0;

  // Packed view: {shift, dout[3:0], lnt, la[1:0], show, sel, active, clear, error}
  logic [12:0] got;
  assign got = {alc_shift, digit_out, load_new_time, load_alarm, show_alarm,
                alarm_sel, entry_active, entry_clear, entry_error};

  function automatic logic [12:0] ex(input logic sh, input logic [3:0] d, input logic lnt,
                                     input logic [1:0] la, input logic shw, input logic sel,
                                     input logic act, input logic clr, input logic err);
    return {sh, d, lnt, la, shw, sel, act, clr, err};
  endfunction

  typedef struct {
    logic [7:0]  code;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] code, input logic [12:0] e);
    vec_t v;
    v.code = code;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [12:0] g, input logic [12:0] e);
    total++;
    if (g === e) passed++;
    else $display("FAIL %s: got %b expected %b (shift,dout,lnt,la,show,sel,act,clr,err)",
                  name, g, e);
  endtask

  // Drives one cycle of inputs starting at a falling edge; returns at the next falling
  // edge, where the registered response to that cycle is visible.
  task automatic drive(input logic stb, input logic [7:0] code, input logic sec);
    key_strobe = stb;
    key        = code;
    one_second = sec;
    @(negedge clk256);
    key_strobe = 1'b0;
    one_second = 1'b0;
  endtask

  initial begin
    // T1: digits 1,2,5,6 with releases, then STAR commits to alarm 0
    add(8'h69, ex(1, 4'd1, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'hF0, ex(0, 4'd1, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h69, ex(0, 4'd1, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h72, ex(1, 4'd2, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'hF0, ex(0, 4'd2, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h72, ex(0, 4'd2, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h73, ex(1, 4'd5, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'hF0, ex(0, 4'd5, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h73, ex(0, 4'd5, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h74, ex(1, 4'd6, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'hF0, ex(0, 4'd6, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h74, ex(0, 4'd6, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h7C, ex(0, 4'd6, 0, 2'b01, 0, 0, 0, 0, 0));
    add(8'hF0, ex(0, 4'd6, 0, 2'b00, 0, 0, 0, 0, 0));
    add(8'h7C, ex(0, 4'd6, 0, 2'b00, 0, 0, 0, 0, 0));
    // Unlisted code and extended prefix in IDLE: no effect
    add(8'h1C, ex(0, 4'd6, 0, 2'b00, 0, 0, 0, 0, 0));
    add(8'hE0, ex(0, 4'd6, 0, 2'b00, 0, 0, 0, 0, 0));
    // T2: typematic repeats of digit 0
    add(8'h70, ex(1, 4'd0, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h70, ex(0, 4'd0, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h70, ex(0, 4'd0, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'hF0, ex(0, 4'd0, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h70, ex(0, 4'd0, 0, 2'b00, 0, 0, 1, 0, 0));
    // DOT cancels
    add(8'h71, ex(0, 4'd0, 0, 2'b00, 0, 0, 0, 1, 0));
    // T3: short entry then MINUS -> error
    add(8'h69, ex(1, 4'd1, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h72, ex(1, 4'd2, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h7B, ex(0, 4'd2, 0, 2'b00, 0, 0, 0, 1, 1));
    // five digits, fifth ignored, MINUS loads time
    add(8'h69, ex(1, 4'd1, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h72, ex(1, 4'd2, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h7A, ex(1, 4'd3, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h6B, ex(1, 4'd4, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h73, ex(0, 4'd4, 0, 2'b00, 0, 0, 1, 0, 0));
    add(8'h7B, ex(0, 4'd4, 1, 2'b00, 0, 0, 0, 0, 0));
    // T5: PLUS x3 -> sel 1,0,1
    add(8'h79, ex(0, 4'd4, 0, 2'b00, 0, 1, 0, 0, 0));
    add(8'hF0, ex(0, 4'd4, 0, 2'b00, 0, 1, 0, 0, 0));
    add(8'h79, ex(0, 4'd4, 0, 2'b00, 0, 1, 0, 0, 0));
    add(8'h79, ex(0, 4'd4, 0, 2'b00, 0, 0, 0, 0, 0));
    add(8'hF0, ex(0, 4'd4, 0, 2'b00, 0, 0, 0, 0, 0));
    add(8'h79, ex(0, 4'd4, 0, 2'b00, 0, 0, 0, 0, 0));
    add(8'h79, ex(0, 4'd4, 0, 2'b00, 0, 1, 0, 0, 0));
    // STAR held; digits and PLUS ignored, sel frozen; release of STAR exits
    add(8'h7C, ex(0, 4'd4, 0, 2'b00, 1, 1, 0, 0, 0));
    add(8'h70, ex(0, 4'd4, 0, 2'b00, 1, 1, 0, 0, 0));
    add(8'h72, ex(0, 4'd4, 0, 2'b00, 1, 1, 0, 0, 0));
    add(8'h79, ex(0, 4'd4, 0, 2'b00, 1, 1, 0, 0, 0));
    add(8'hF0, ex(0, 4'd4, 0, 2'b00, 1, 1, 0, 0, 0));
    add(8'h7C, ex(0, 4'd4, 0, 2'b00, 0, 1, 0, 0, 0));
    // full entry committed to alarm 1
    add(8'h70, ex(1, 4'd0, 0, 2'b00, 0, 1, 1, 0, 0));
    add(8'h69, ex(1, 4'd1, 0, 2'b00, 0, 1, 1, 0, 0));
    add(8'h72, ex(1, 4'd2, 0, 2'b00, 0, 1, 1, 0, 0));
    add(8'h7A, ex(1, 4'd3, 0, 2'b00, 0, 1, 1, 0, 0));
    add(8'h7C, ex(0, 4'd3, 0, 2'b10, 0, 1, 0, 0, 0));
    add(8'hF0, ex(0, 4'd3, 0, 2'b00, 0, 1, 0, 0, 0));
    add(8'h7C, ex(0, 4'd3, 0, 2'b00, 0, 1, 0, 0, 0));

    reset = 1'b1;
    repeat (2) @(negedge clk256);
    check("reset_state", got, 13'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].code, 1'b0);
      check($sformatf("vec%0d_key%h", i, vecs[i].code), got, vecs[i].exp);
    end

    // T4a: plain timeout after 10 one_second strobes
    drive(1'b1, 8'h72, 1'b0);
    check("t4_start", got, ex(1, 4'd2, 0, 2'b00, 0, 1, 1, 0, 0));
    for (int s = 1; s <= 10; s++) begin
      drive(1'b0, 8'h00, 1'b1);
      check($sformatf("t4a_sec%0d", s), got,
            ex(0, 4'd2, 0, 2'b00, 0, 1, (s < 10), (s == 10), 0));
      drive(1'b0, 8'h00, 1'b0);
    end

    // T4b: key on the 9th strobe reloads the timer
    drive(1'b1, 8'h69, 1'b0);
    check("t4b_start", got, ex(1, 4'd1, 0, 2'b00, 0, 1, 1, 0, 0));
    for (int s = 1; s <= 8; s++) begin
      drive(1'b0, 8'h00, 1'b1);
      drive(1'b0, 8'h00, 1'b0);
    end
    drive(1'b1, 8'h7A, 1'b1);
    check("t4b_key_on_sec9", got, ex(1, 4'd3, 0, 2'b00, 0, 1, 1, 0, 0));
    for (int s = 1; s <= 10; s++) begin
      drive(1'b0, 8'h00, 1'b1);
      check($sformatf("t4b_sec%0d", s), got,
            ex(0, 4'd3, 0, 2'b00, 0, 1, (s < 10), (s == 10), 0));
      drive(1'b0, 8'h00, 1'b0);
    end

    // T6: reset mid-entry, then count restarts at 1
    drive(1'b1, 8'h70, 1'b0);
    check("t6_d1", got, ex(1, 4'd0, 0, 2'b00, 0, 1, 1, 0, 0));
    drive(1'b1, 8'h69, 1'b0);
    check("t6_d2", got, ex(1, 4'd1, 0, 2'b00, 0, 1, 1, 0, 0));
    reset = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    check("t6_reset", got, 13'd0);
    reset = 1'b0;
    drive(1'b1, 8'h72, 1'b0);
    check("t6_r1", got, ex(1, 4'd2, 0, 2'b00, 0, 0, 1, 0, 0));
    drive(1'b1, 8'h7A, 1'b0);
    check("t6_r2", got, ex(1, 4'd3, 0, 2'b00, 0, 0, 1, 0, 0));
    drive(1'b1, 8'h6B, 1'b0);
    check("t6_r3", got, ex(1, 4'd4, 0, 2'b00, 0, 0, 1, 0, 0));
    drive(1'b1, 8'h73, 1'b0);
    check("t6_r4", got, ex(1, 4'd5, 0, 2'b00, 0, 0, 1, 0, 0));
    drive(1'b1, 8'h7C, 1'b0);
    check("t6_commit", got, ex(0, 4'd5, 0, 2'b01, 0, 0, 0, 0, 0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
